// File: rtl/code_seq_pkg.sv
// Shared definitions for the code-sequence detector: one-hot state encodings,
// counter width and the helper that sizes the step index.
package code_seq_pkg;

    localparam int unsigned StateW = 4;
    localparam int unsigned CntW   = 8;

    localparam logic [StateW-1:0] StIdle   = 4'b0001;
    localparam logic [StateW-1:0] StGap    = 4'b0010;
    localparam logic [StateW-1:0] StCheck  = 4'b0100;
    localparam logic [StateW-1:0] StActive = 4'b1000;

    // Step must be able to count from 0 up to seq_len inclusive.
    function automatic int unsigned step_width(input int unsigned seq_len);
        return $clog2(seq_len + 1);
    endfunction

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable 8-bit down counter with a zero flag; decrement saturates at zero so
// the value never wraps.
module cycle_down_counter
    import code_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [CntW-1:0] load_val,
    input  logic            dec,
    output logic [CntW-1:0] count,
    output logic            zero
);

    logic [CntW-1:0] count_d, count_q;

    // Load wins over decrement; decrement stops at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/code_sequence_fsm.sv
// Code-sequence detector: watches b for a programmed series of masked codes,
// each separated by a fixed idle gap, and holds outp high for a fixed time once
// the whole series is seen. A wrong code aborts with a one-cycle err pulse.
module code_sequence_fsm
    import code_seq_pkg::*;
#(
    parameter int unsigned B_WIDTH     = 3,
    parameter int unsigned SEQ_LEN     = 2,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           clr,
    input  logic [B_WIDTH-1:0]             b,
    input  logic [SEQ_LEN*B_WIDTH-1:0]     codes,
    input  logic [B_WIDTH-1:0]             mask,
    output logic                           outp,
    output logic                           busy,
    output logic                           err,
    output logic [step_width(SEQ_LEN)-1:0] step
);

    localparam int unsigned StepW = step_width(SEQ_LEN);

    if (B_WIDTH < 1 || B_WIDTH > 16) begin : g_bad_b_width
        $error("code_sequence_fsm: B_WIDTH must be 1..16");
    end
    if (SEQ_LEN < 2 || SEQ_LEN > 8) begin : g_bad_seq_len
        $error("code_sequence_fsm: SEQ_LEN must be 2..8");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
        $error("code_sequence_fsm: GAP_CYCLES must be 1..255");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("code_sequence_fsm: HOLD_CYCLES must be 1..255");
    end

    logic [StateW-1:0]  state_d, state_q;
    logic [StepW-1:0]   step_d, step_q;
    logic               err_d, err_q;
    logic               outp_q, busy_q;
    logic [B_WIDTH-1:0] code_sel;
    logic               match_first, match_step, last_step, state_legal;
    logic               cnt_load, cnt_dec, cnt_zero, cnt_done;
    logic [CntW-1:0]    cnt_load_val, cnt_count;

    // An all-zero masked input is treated as "no code present" and never matches.
    function automatic logic code_match(input logic [B_WIDTH-1:0] value,
                                        input logic [B_WIDTH-1:0] code,
                                        input logic [B_WIDTH-1:0] care);
        return (((value ^ code) & care) == '0) && ((value & care) != '0);
    endfunction

    // Select the code addressed by the current step index.
    always_comb begin
        code_sel = '0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            if (step_q == StepW'(k)) begin
                code_sel = codes[k*B_WIDTH +: B_WIDTH];
            end
        end
    end

    assign match_first = code_match(b, codes[B_WIDTH-1:0], mask);
    assign match_step  = code_match(b, code_sel, mask);
    assign last_step   = (step_q == StepW'(SEQ_LEN - 1));
    assign state_legal = $onehot(state_q);
    // Zero also ends a phase so a counter that somehow reads zero cannot stall it.
    assign cnt_done    = cnt_zero || (cnt_count == CntW'(1));

    // Shared timer for the GAP and ACTIVE phases.
    cycle_down_counter u_cycle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    // Next-state, step and timer control; clr and illegal states ignore en.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        err_d        = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        if (clr || !state_legal) begin
            state_d  = StIdle;
            step_d   = '0;
            cnt_load = 1'b1;
        end else if (en) begin
            unique case (state_q)
                StIdle: begin
                    if (match_first) begin
                        state_d      = StGap;
                        step_d       = StepW'(1);
                        cnt_load     = 1'b1;
                        cnt_load_val = CntW'(GAP_CYCLES);
                    end
                end
                StGap: begin
                    cnt_dec = 1'b1;
                    if (cnt_done) begin
                        state_d = StCheck;
                    end
                end
                StCheck: begin
                    if (match_step && last_step) begin
                        state_d      = StActive;
                        cnt_load     = 1'b1;
                        cnt_load_val = CntW'(HOLD_CYCLES);
                    end else if (match_step) begin
                        state_d      = StGap;
                        step_d       = step_q + 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = CntW'(GAP_CYCLES);
                    end else begin
                        state_d = StIdle;
                        step_d  = '0;
                        err_d   = 1'b1;
                    end
                end
                StActive: begin
                    cnt_dec = 1'b1;
                    if (cnt_done) begin
                        state_d = StIdle;
                        step_d  = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    step_d  = '0;
                end
            endcase
        end
    end

    // State and registered outputs; outp/busy derive from the next state so they
    // line up exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= '0;
            outp_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            outp_q  <= (state_d == StActive);
            busy_q  <= (state_d != StIdle);
            err_q   <= err_d;
        end
    end

    assign outp = outp_q;
    assign busy = busy_q;
    assign err  = err_q;
    assign step = step_q;

endmodule

// File: tb/tb_code_sequence_fsm.sv
// Bench for code_sequence_fsm: a default instance and a SEQ_LEN=3 instance share
// stimulus; a progress-count reference model predicts every output each cycle.
module tb_code_sequence_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [2:0] b;
    logic [2:0] mask;

    logic       outp_a, busy_a, err_a;
    logic [1:0] step_a;
    logic       outp_b, busy_b, err_b;
    logic [1:0] step_b;

    int checks = 0;
    int errors = 0;
    int hi_a   = 0;
    int hi_b   = 0;
    int errs_a = 0;

    // Reference model: index 0 = default instance, 1 = three-code instance.
    // matched = codes accepted so far, wait_left = gap cycles still to idle,
    // hold_left = outp cycles still to go.
    int p_len[2]     = '{2, 3};
    int p_gap[2]     = '{2, 1};
    int p_hold[2]    = '{4, 2};
    int p_code[2][3] = '{'{1, 2, 0}, '{1, 2, 3}};
    int matched[2];
    int wait_left[2];
    int hold_left[2];
    bit merr[2];

    logic [2:0] mlist[4] = '{3'b011, 3'b111, 3'b110, 3'b010};
    logic [2:0] clist[3] = '{3'b001, 3'b010, 3'b011};

    code_sequence_fsm dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .b     (b),
        .codes ({3'b010, 3'b001}),
        .mask  (mask),
        .outp  (outp_a),
        .busy  (busy_a),
        .err   (err_a),
        .step  (step_a)
    );

    code_sequence_fsm #(
        .B_WIDTH     (3),
        .SEQ_LEN     (3),
        .GAP_CYCLES  (1),
        .HOLD_CYCLES (2)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .b     (b),
        .codes ({3'b011, 3'b010, 3'b001}),
        .mask  (mask),
        .outp  (outp_b),
        .busy  (busy_b),
        .err   (err_b),
        .step  (step_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic bit is_match(input int bv, input int code, input int mk);
        return (((bv ^ code) & mk) == 0) && ((bv & mk) != 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            matched[i]   = 0;
            wait_left[i] = 0;
            hold_left[i] = 0;
            merr[i]      = 1'b0;
        end
    endtask

    task automatic model_edge(input int bv, input int mk, input bit env, input bit clrv);
        for (int i = 0; i < 2; i++) begin
            merr[i] = 1'b0;
            if (clrv) begin
                matched[i]   = 0;
                wait_left[i] = 0;
                hold_left[i] = 0;
            end else if (env) begin
                if (hold_left[i] > 0) begin
                    hold_left[i]--;
                    if (hold_left[i] == 0) matched[i] = 0;
                end else if (matched[i] == 0) begin
                    if (is_match(bv, p_code[i][0], mk)) begin
                        matched[i]   = 1;
                        wait_left[i] = p_gap[i];
                    end
                end else if (wait_left[i] > 0) begin
                    wait_left[i]--;
                end else if (is_match(bv, p_code[i][matched[i]], mk)) begin
                    matched[i]++;
                    if (matched[i] == p_len[i]) hold_left[i] = p_hold[i];
                    else wait_left[i] = p_gap[i];
                end else begin
                    matched[i] = 0;
                    merr[i]    = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("outp_a", 32'(outp_a), 32'(hold_left[0] > 0));
        chk("busy_a", 32'(busy_a), 32'(matched[0] > 0));
        chk("err_a",  32'(err_a),  32'(merr[0]));
        chk("outp_b", 32'(outp_b), 32'(hold_left[1] > 0));
        chk("busy_b", 32'(busy_b), 32'(matched[1] > 0));
        chk("err_b",  32'(err_b),  32'(merr[1]));
        // Step is only defined by the model while a code is still outstanding.
        if (hold_left[0] == 0) chk("step_a", 32'(step_a), 32'(matched[0]));
        if (hold_left[1] == 0) chk("step_b", 32'(step_b), 32'(matched[1]));
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
    task automatic cyc(input logic [2:0] bv, input bit env, input bit clrv);
        b   = bv;
        en  = env;
        clr = clrv;
        @(posedge clk);
        model_edge(int'(bv), int'(mask), env, clrv);
        #1;
        compare_all();
        if (outp_a === 1'b1) hi_a++;
        if (outp_b === 1'b1) hi_b++;
        if (err_a === 1'b1) errs_a++;
    endtask

    // Asynchronous reset pulse starting mid-cycle, released on a falling edge.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        chk("rst_outp_a", 32'(outp_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        chk("rst_step_b", 32'(step_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        clr   = 1'b0;
        b     = 3'b000;
        mask  = 3'b011;
        model_reset();

        // Reset state
        #2 rst_n = 1'b0;
        #1 compare_all();
        chk("reset_step_a", 32'(step_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc(3'b000, 1'b1, 1'b0);

        // Two-code accept with default timing
        hi_a = 0; errs_a = 0;
        cyc(3'b001, 1'b1, 1'b0);
        cyc(3'b000, 1'b1, 1'b0);
        cyc(3'b000, 1'b1, 1'b0);
        cyc(3'b010, 1'b1, 1'b0);
        chk("accept_outp_c4", 32'(outp_a), 32'd1);
        repeat (4) cyc(3'b000, 1'b1, 1'b0);
        chk("accept_idle_c8", 32'(busy_a), 32'd0);
        chk("accept_hold_len", 32'(hi_a), 32'd4);
        chk("accept_no_err", 32'(errs_a), 32'd0);
        repeat (4) cyc(3'b000, 1'b1, 1'b0);

        // Wrong second code (masked to zero)
        cyc(3'b001, 1'b1, 1'b0);
        cyc(3'b000, 1'b1, 1'b0);
        cyc(3'b000, 1'b1, 1'b0);
        cyc(3'b100, 1'b1, 1'b0);
        chk("mismatch_err_c4", 32'(err_a), 32'd1);
        chk("mismatch_idle_c4", 32'(busy_a), 32'd0);
        cyc(3'b000, 1'b1, 1'b0);
        chk("mismatch_err_c5", 32'(err_a), 32'd0);
        repeat (6) cyc(3'b000, 1'b1, 1'b0);

        // Three-code instance: step 1, 2, then a two-cycle hold
        hi_b = 0;
        cyc(3'b001, 1'b1, 1'b0);
        chk("seq3_step1", 32'(step_b), 32'd1);
        cyc(3'b000, 1'b1, 1'b0);
        cyc(3'b010, 1'b1, 1'b0);
        chk("seq3_step2", 32'(step_b), 32'd2);
        cyc(3'b000, 1'b1, 1'b0);
        cyc(3'b011, 1'b1, 1'b0);
        chk("seq3_outp", 32'(outp_b), 32'd1);
        repeat (3) cyc(3'b000, 1'b1, 1'b0);
        chk("seq3_hold_len", 32'(hi_b), 32'd2);
        repeat (6) cyc(3'b000, 1'b1, 1'b0);

        // en low for three cycles in the middle of GAP
        hi_a = 0;
        cyc(3'b001, 1'b1, 1'b0);
        cyc(3'b000, 1'b1, 1'b0);
        repeat (3) cyc(3'b000, 1'b0, 1'b0);
        cyc(3'b000, 1'b1, 1'b0);
        chk("stall_busy_c6", 32'(busy_a), 32'd1);
        cyc(3'b010, 1'b1, 1'b0);
        chk("stall_outp_c7", 32'(outp_a), 32'd1);
        repeat (4) cyc(3'b000, 1'b1, 1'b0);
        chk("stall_hold_len", 32'(hi_a), 32'd4);
        repeat (4) cyc(3'b000, 1'b1, 1'b0);

        // clr during the second ACTIVE cycle
        errs_a = 0;
        cyc(3'b001, 1'b1, 1'b0);
        cyc(3'b000, 1'b1, 1'b0);
        cyc(3'b000, 1'b1, 1'b0);
        cyc(3'b010, 1'b1, 1'b0);
        cyc(3'b000, 1'b1, 1'b0);
        cyc(3'b000, 1'b1, 1'b1);
        chk("clr_outp", 32'(outp_a), 32'd0);
        chk("clr_busy", 32'(busy_a), 32'd0);
        chk("clr_step", 32'(step_a), 32'd0);
        cyc(3'b000, 1'b1, 1'b0);
        chk("clr_no_err", 32'(errs_a), 32'd0);

        // Asynchronous reset mid-GAP
        cyc(3'b001, 1'b1, 1'b0);
        pulse_reset();
        repeat (3) cyc(3'b000, 1'b1, 1'b0);

        // Masked-zero inputs never start a sequence
        mask = 3'b111;
        repeat (10) cyc(3'b000, 1'b1, 1'b0);
        chk("zero_input_idle", 32'(busy_a), 32'd0);
        mask = 3'b000;
        for (int n = 0; n < 20; n++) begin
            cyc(3'($urandom_range(0, 7)), 1'b1, 1'b0);
            chk("mask0_idle_a", 32'(busy_a), 32'd0);
            chk("mask0_idle_b", 32'(busy_b), 32'd0);
        end

        // Randomised traffic against the model
        mask = 3'b011;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) == 0) mask = mlist[$urandom_range(0, 3)];
            if ($urandom_range(0, 299) == 0) pulse_reset();
            cyc(($urandom_range(0, 1) == 1) ? clist[$urandom_range(0, 2)]
                                            : 3'($urandom_range(0, 7)),
                $urandom_range(0, 9) != 0,
                $urandom_range(0, 39) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
